// File: rtl/csi2_pattern_tx.sv
// CSI-2 style byte-stream test-pattern transmitter: FS, NUM_LINES long packets, FE per frame,
// NUM_FRAMES frames per enable run, with ready-stall timeout detection.
module csi2_pattern_tx #(
  parameter int         LINE_BYTES = 16,
  parameter int         NUM_LINES  = 4,
  parameter int         NUM_FRAMES = 2,
  parameter logic [7:0] DATA_TYPE  = 8'h2A,
  parameter logic [1:0] VC         = 2'd0,
  parameter int         STALL_MAX  = 1024
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       enable_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_sop_o,
  output logic       tx_eop_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int              SW         = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX);
  localparam logic [SW-1:0]   STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [15:0]     LB_LAST    = 16'(LINE_BYTES - 1);
  localparam logic [15:0]     LB_WC      = 16'(LINE_BYTES);
  localparam logic [31:0]     NL_LAST    = 32'(NUM_LINES - 1);
  localparam logic [31:0]     NF_LAST    = 32'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FS, S_LH, S_PAY, S_CRC, S_FE, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [31:0]   line_q, line_d;
  logic [31:0]   frm_q, frm_d;
  logic [15:0]   frame_no_q, frame_d;
  logic [15:0]   crc_q, crc_d;
  logic [SW-1:0] stall_q;
  logic [7:0]    data_q, data_d;
  logic          valid_q, sop_q, eop_q, sop_d, eop_d, done_q, error_q;
  logic [7:0]    hdr_di;
  logic [15:0]   hdr_wc;
  logic [5:0]    hdr_ecc;
  logic          sending, advance;

  function automatic logic [5:0] ecc6(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  assign sending = (state_q == S_FS) || (state_q == S_LH) || (state_q == S_PAY) ||
                   (state_q == S_CRC) || (state_q == S_FE);
  assign advance = (state_q == S_IDLE) ? enable_i : (sending && tx_ready_i);

  // Position of the byte that follows the current one, and that byte's value.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + 16'd1;
    line_d  = line_q;
    frm_d   = frm_q;
    frame_d = frame_no_q;
    crc_d   = crc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FS; idx_d = '0; line_d = '0; frm_d = '0;
      end
      S_FS: if (idx_q == 16'd3) begin
        state_d = S_LH; idx_d = '0; line_d = '0;
      end
      S_LH: if (idx_q == 16'd3) begin
        state_d = S_PAY; idx_d = '0; crc_d = 16'hFFFF;
      end
      S_PAY: begin
        crc_d = crc_step(crc_q, data_q);
        if (idx_q == LB_LAST) begin
          state_d = S_CRC; idx_d = '0;
        end
      end
      S_CRC: if (idx_q == 16'd1) begin
        idx_d = '0;
        if (line_q == NL_LAST) state_d = S_FE;
        else begin
          state_d = S_LH; line_d = line_q + 32'd1;
        end
      end
      S_FE: if (idx_q == 16'd3) begin
        idx_d   = '0;
        frame_d = (frame_no_q == 16'hFFFF) ? 16'h0001 : frame_no_q + 16'd1;
        if (frm_q == NF_LAST) state_d = S_DONE;
        else begin
          state_d = S_FS; frm_d = frm_q + 32'd1;
        end
      end
      default: ;
    endcase

    hdr_di = 8'h00;
    hdr_wc = frame_d;
    case (state_d)
      S_FS: hdr_di = {VC, 6'h00};
      S_FE: hdr_di = {VC, 6'h01};
      S_LH: begin
        hdr_di = {VC, DATA_TYPE[5:0]}; hdr_wc = LB_WC;
      end
      default: ;
    endcase
    hdr_ecc = ecc6({hdr_wc, hdr_di});

    data_d = 8'h00;
    sop_d  = 1'b0;
    eop_d  = 1'b0;
    case (state_d)
      S_FS, S_LH, S_FE: begin
        case (idx_d[1:0])
          2'd0:    data_d = hdr_di;
          2'd1:    data_d = hdr_wc[7:0];
          2'd2:    data_d = hdr_wc[15:8];
          default: data_d = {2'b00, hdr_ecc};
        endcase
        sop_d = (idx_d == 16'd0);
        eop_d = (idx_d == 16'd3) && (state_d != S_LH);
      end
      S_PAY: data_d = line_d[7:0] + idx_d[7:0] + frame_d[7:0];
      S_CRC: begin
        data_d = idx_d[0] ? crc_d[15:8] : crc_d[7:0];
        eop_d  = idx_d[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      line_q     <= '0;
      frm_q      <= '0;
      frame_no_q <= 16'd1;
      crc_q      <= 16'hFFFF;
      stall_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (advance) begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      line_q     <= line_d;
      frm_q      <= frm_d;
      frame_no_q <= frame_d;
      crc_q      <= crc_d;
      stall_q    <= '0;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      valid_q    <= (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
    end else if (sending && stall_q == STALL_LAST) begin
      state_q <= S_ERR;
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      error_q <= 1'b1;
    end else if (sending) begin
      stall_q <= stall_q + 1'b1;
    end else if (state_q == S_DONE && !enable_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;
  assign tx_sop_o   = sop_q;
  assign tx_eop_o   = eop_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_csi2_pattern_tx.sv
// Scoreboard bench for csi2_pattern_tx: stimulus pushes the expected byte stream,
// a negedge monitor pops and compares every accepted byte.
module tb_csi2_pattern_tx;

  localparam int LB = 16;
  localparam int NL = 4;
  localparam int NF = 2;
  localparam int SMAX = 1024;

  // ECC contribution of each header bit D0..D23
  localparam logic [5:0] ECC_TAB [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       enable_i = 1'b0;
  logic       tx_ready_i = 1'b1;
  logic [7:0] tx_data_o;
  logic       tx_valid_o, tx_sop_o, tx_eop_o, done_o, error_o;

  typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;

  beat_t       exp_q[$];
  logic [7:0]  log_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_frame = 16'd1;
  bit          rand_ready = 1'b0;

  always #5 clk_i = ~clk_i;

  csi2_pattern_tx #(
    .LINE_BYTES(LB), .NUM_LINES(NL), .NUM_FRAMES(NF),
    .DATA_TYPE(8'h2A), .VC(2'd0), .STALL_MAX(SMAX)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_sop_o(tx_sop_o), .tx_eop_o(tx_eop_o), .done_o(done_o), .error_o(error_o)
  );

  function automatic logic [5:0] ecc_model(input logic [23:0] d);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 24; i++) if (d[i]) r = r ^ ECC_TAB[i];
    return r;
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = b ^ c[7:0];
    x = x ^ {x[3:0], 4'h0};
    return {8'h00, c[15:8]} ^ {x, 8'h00} ^ {5'b00000, x, 3'b000} ^ {12'h000, x[7:4]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [7:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d; b.sop = s; b.eop = e;
    exp_q.push_back(b);
  endtask

  task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc, input logic last_is_eop);
    push_beat(di, 1'b1, 1'b0);
    push_beat(wc[7:0], 1'b0, 1'b0);
    push_beat(wc[15:8], 1'b0, 1'b0);
    push_beat({2'b00, ecc_model({wc, di})}, 1'b0, last_is_eop);
  endtask

  task automatic push_run();
    logic [15:0] f, crc;
    logic [7:0]  b;
    f = model_frame;
    for (int fr = 0; fr < NF; fr++) begin
      push_hdr(8'h00, f, 1'b1);
      for (int l = 0; l < NL; l++) begin
        push_hdr(8'h2A, 16'(LB), 1'b0);
        crc = 16'hFFFF;
        for (int k = 0; k < LB; k++) begin
          b = 8'(l + k + int'(f[7:0]));
          push_beat(b, 1'b0, 1'b0);
          crc = crc_model(crc, b);
        end
        push_beat(crc[7:0], 1'b0, 1'b0);
        push_beat(crc[15:8], 1'b0, 1'b1);
      end
      push_hdr(8'h01, f, 1'b1);
      f = (f == 16'hFFFF) ? 16'h0001 : f + 16'd1;
    end
    model_frame = f;
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (log_q.size() < i + 4) return 32'hDEAD_BEEF;
    return {log_q[i], log_q[i+1], log_q[i+2], log_q[i+3]};
  endfunction

  task automatic wait_done(input int max_cyc);
    int c;
    c = 0;
    @(negedge clk_i);
    while (!done_o && c < max_cyc) begin
      @(negedge clk_i);
      c++;
    end
    check("done_seen", 32'(done_o), 32'd1);
  endtask

  task automatic wait_valid(input int max_cyc);
    int c;
    c = 0;
    @(negedge clk_i);
    while (!tx_valid_o && c < max_cyc) begin
      @(negedge clk_i);
      c++;
    end
    check("valid_seen", 32'(tx_valid_o), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drop_enable_check_done(input string tag);
    tick();
    enable_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_done_held"}, 32'(done_o), 32'd1);
    @(negedge clk_i);
    check({tag, "_done_clear"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_ready) tx_ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares each accepted byte and checks hold stability under stall.
  initial begin
    beat_t      e;
    logic       pv, pr, ps, pe;
    logic [7:0] pd, cur_di;
    int         cur_len, pkt_no;
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pe = 1'b0; pd = '0;
    cur_di = '0; cur_len = 0; pkt_no = 0;
    forever begin
      @(negedge clk_i);
      if (reset_n_i && tx_valid_o) begin
        if (pv && !pr)
          check("hold_while_stalled", {22'd0, tx_data_o, tx_sop_o, tx_eop_o}, {22'd0, pd, ps, pe});
        if (tx_ready_i) begin
          log_q.push_back(tx_data_o);
          if (tx_sop_o) begin
            cur_di = tx_data_o;
            cur_len = 0;
          end
          cur_len++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", tx_data_o);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {22'd0, tx_data_o, tx_sop_o, tx_eop_o}, {22'd0, e.d, e.sop, e.eop});
          end
          if (tx_eop_o) begin
            pkt_no++;
            $display("pkt %0d: di=0x%02h len=%0d", pkt_no, cur_di, cur_len);
          end
        end
      end
      pv = reset_n_i && tx_valid_o;
      pr = tx_ready_i;
      pd = tx_data_o;
      ps = tx_sop_o;
      pe = tx_eop_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    int          cnt;
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_model(c, 8'(8'h31 + i));
    if (c != 16'h6F91) begin
      $display("FAIL crc_model_selftest: got 0x%04h, expected 0x6f91", c);
      $fatal(1, "bench CRC model broken");
    end

    // Reset state
    repeat (3) tick();
    @(negedge clk_i);
    check("reset_outputs", {22'd0, tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, done_o, error_o}, 32'd0);
    tick();
    reset_n_i = 1'b1;

    // Run 1: ready always high, frames 1 and 2
    push_run();
    log_q.delete();
    tick();
    enable_i = 1'b1;
    @(negedge clk_i);
    check("idle_before_start", 32'(tx_valid_o), 32'd0);
    @(negedge clk_i);
    check("valid_first_fs", 32'(tx_valid_o), 32'd1);
    cnt = 0;
    while (tx_valid_o && cnt < 400) begin
      cnt++;
      @(negedge clk_i);
    end
    check("burst_len", 32'(cnt), 32'd192);
    check("done_after_last", 32'(done_o), 32'd1);
    check("logged_bytes", 32'(log_q.size()), 32'd192);
    check("fs1_header", word_at(0), 32'h0001_001A);
    check("lh_header", word_at(4), 32'h2A10_0036);
    check("f1_l0_first_pay", 32'(log_q[8]), 32'h01);
    check("f1_l0_last_pay", 32'(log_q[23]), 32'h10);
    check("fs2_header", word_at(96), 32'h0002_001C);
    check("run1_drained", 32'(exp_q.size()), 32'd0);
    drop_enable_check_done("run1");

    // Run 2: random ready, frames 3 and 4
    push_run();
    rand_ready = 1'b1;
    tick();
    enable_i = 1'b1;
    wait_done(3000);
    rand_ready = 1'b0;
    tx_ready_i = 1'b1;
    check("run2_drained", 32'(exp_q.size()), 32'd0);
    check("run2_no_error", 32'(error_o), 32'd0);
    drop_enable_check_done("run2");

    // Reset in the middle of line 0 payload, then restart from frame 1
    push_run();
    tick();
    enable_i = 1'b1;
    wait_valid(10);
    repeat (10) @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    enable_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    check("reset_midrun", {22'd0, tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, done_o, error_o}, 32'd0);
    tick();
    reset_n_i = 1'b1;
    model_frame = 16'd1;
    push_run();
    log_q.delete();
    tick();
    enable_i = 1'b1;
    wait_done(400);
    check("fs_after_reset", word_at(0), 32'h0001_001A);
    check("run3_drained", 32'(exp_q.size()), 32'd0);
    drop_enable_check_done("run3");

    // Frame number wrap: 0xFFFF then 0x0001
    @(negedge clk_i);
    force dut.frame_no_q = 16'hFFFF;
    model_frame = 16'hFFFF;
    push_run();
    log_q.delete();
    tick();
    enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    release dut.frame_no_q;
    wait_done(400);
    check("fs_ffff", word_at(0), 32'h00FF_FF3A);
    check("pay_ffff", 32'(log_q[8]), 32'hFF);
    check("fe_ffff", word_at(92), 32'h01FF_FF3D);
    check("fs_wrap_0001", word_at(96), 32'h0001_001A);
    check("run4_drained", 32'(exp_q.size()), 32'd0);
    drop_enable_check_done("run4");

    // Acceptance exactly at the last allowed stall cycle is not an error
    push_run();
    tx_ready_i = 1'b0;
    tick();
    enable_i = 1'b1;
    wait_valid(10);
    repeat (SMAX - 1) @(posedge clk_i);
    #1;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    check("accept_at_limit_no_err", 32'(error_o), 32'd0);
    wait_done(400);
    check("limit_run_no_error", 32'(error_o), 32'd0);
    check("run5_drained", 32'(exp_q.size()), 32'd0);
    drop_enable_check_done("run5");

    // Stall timeout
    tx_ready_i = 1'b0;
    tick();
    enable_i = 1'b1;
    wait_valid(10);
    repeat (SMAX - 1) @(posedge clk_i);
    @(negedge clk_i);
    check("no_err_before_limit", {30'd0, error_o, tx_valid_o}, 32'h1);
    @(negedge clk_i);
    check("err_at_limit", {29'd0, error_o, tx_valid_o, done_o}, 32'h4);
    tick();
    enable_i = 1'b0;
    repeat (5) tick();
    @(negedge clk_i);
    check("err_sticky", {29'd0, error_o, tx_valid_o, done_o}, 32'h4);
    tick();
    reset_n_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("err_cleared_by_reset", 32'(error_o), 32'd0);
    reset_n_i = 1'b1;
    tx_ready_i = 1'b1;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
